// File: rtl/bcd_display_scanner_pkg.sv
// Shared types and constants for the BCD display scanner.
package bcd_display_scanner_pkg;

  // Conversion engine states.
  typedef enum logic [1:0] {
    StIdle,
    StConv,
    StCommit
  } conv_state_e;

  localparam int unsigned BCD_W    = 4;
  localparam int unsigned MAX_DISP = 9999;

  // Digit-index width; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned digits);
    return (digits > 1) ? $clog2(digits) : 1;
  endfunction

  // Double-dabble correction: a nibble of 5 or more becomes >= 8 after +3,
  // so the following left shift carries into the next decade.
  function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] nib);
    return (nib >= 4'd5) ? nib + 4'd3 : nib;
  endfunction

endpackage

// File: rtl/bcd_display_scanner_if.sv
// Load/status and multiplexed display bus for the BCD display scanner.
interface bcd_display_scanner_if #(
  parameter int unsigned BIN_W  = 14,
  parameter int unsigned DIGITS = 4
);
  logic              load;
  logic [BIN_W-1:0]  bin_in;
  logic              busy;
  logic              done;
  logic              overflow;
  logic              bcd_a;
  logic              bcd_b;
  logic              bcd_c;
  logic              bcd_d;
  logic [DIGITS-1:0] digit_en_n;

  // Requester side: issues loads and watches the display outputs.
  modport master (
    output load, bin_in,
    input  busy, done, overflow, bcd_a, bcd_b, bcd_c, bcd_d, digit_en_n
  );

  // Scanner side.
  modport slave (
    input  load, bin_in,
    output busy, done, overflow, bcd_a, bcd_b, bcd_c, bcd_d, digit_en_n
  );
endinterface

// File: rtl/bcd_display_scanner_bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3), one bit per clock.
module bin2bcd_seq
  import bcd_display_scanner_pkg::*;
#(
  parameter int unsigned BIN_W  = 14,
  parameter int unsigned DIGITS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load_i,
  input  logic [BIN_W-1:0]          bin_i,
  output logic                      busy_o,
  output logic                      commit_o,
  output logic [DIGITS*BCD_W-1:0]   bcd_o,
  output logic                      done_o,
  output logic                      overflow_o
);

  localparam int unsigned BcdBits = DIGITS * BCD_W;
  localparam int unsigned CntW    = $clog2(BIN_W + 1);

  conv_state_e        state_q, state_d;
  logic [BcdBits-1:0] bcd_q, bcd_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic               done_q, done_d;

  logic               over;
  logic [BIN_W-1:0]   operand;
  logic [BcdBits-1:0] adj;

  // Saturate inputs above the largest displayable value.
  always_comb begin
    over    = 32'(bin_i) > MAX_DISP;
    operand = over ? BIN_W'(MAX_DISP) : bin_i;
  end

  // Per-nibble +3 correction ahead of each shift.
  always_comb begin
    adj = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      adj[i*BCD_W +: BCD_W] = add3(bcd_q[i*BCD_W +: BCD_W]);
    end
  end

  // FSM next state and datapath updates.
  always_comb begin
    state_d = state_q;
    bcd_d   = bcd_q;
    bin_d   = bin_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (load_i) begin
          bin_d   = operand;
          bcd_d   = '0;
          cnt_d   = '0;
          ovf_d   = over;
          state_d = StConv;
        end
      end
      StConv: begin
        {bcd_d, bin_d} = {adj, bin_q} << 1;
        cnt_d          = cnt_q + 1'b1;
        if (cnt_q == CntW'(BIN_W - 1)) begin
          state_d = StCommit;
        end
      end
      StCommit: begin
        state_d = StIdle;
        done_d  = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      bcd_q   <= '0;
      bin_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bcd_q   <= bcd_d;
      bin_q   <= bin_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign busy_o     = (state_q != StIdle);
  assign commit_o   = (state_q == StCommit);
  assign bcd_o      = bcd_q;
  assign done_o     = done_q;
  assign overflow_o = ovf_q;

endmodule

// File: rtl/bcd_display_scanner.sv
// Binary balance to 4-digit multiplexed BCD display driver with blanking.
module bcd_display_scanner
  import bcd_display_scanner_pkg::*;
#(
  parameter int unsigned BIN_W    = 14,
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned SCAN_DIV = 50000
) (
  input logic                  clk,
  input logic                  rst,
  bcd_display_scanner_if.slave bus
);

  localparam int unsigned BcdBits = DIGITS * BCD_W;
  localparam int unsigned IdxW    = idx_width(DIGITS);
  localparam int unsigned PreW    = $clog2(SCAN_DIV);

  logic [BcdBits-1:0] conv_bcd;
  logic               conv_commit;

  logic [BcdBits-1:0] disp_q, disp_d;
  logic [PreW-1:0]    presc_q, presc_d;
  logic [IdxW-1:0]    idx_q, idx_d;
  logic [BCD_W-1:0]   bcd_out_q, bcd_out_d;
  logic [DIGITS-1:0]  en_q, en_d;
  logic               presc_tc;
  logic               upper_zero;

  bin2bcd_seq #(
    .BIN_W  (BIN_W),
    .DIGITS (DIGITS)
  ) u_conv (
    .clk        (clk),
    .rst        (rst),
    .load_i     (bus.load),
    .bin_i      (bus.bin_in),
    .busy_o     (bus.busy),
    .commit_o   (conv_commit),
    .bcd_o      (conv_bcd),
    .done_o     (bus.done),
    .overflow_o (bus.overflow)
  );

  // Display register only changes on commit, so partial results never show.
  always_comb begin
    disp_d = conv_commit ? conv_bcd : disp_q;
  end

  // Scan prescaler and digit index.
  always_comb begin
    presc_tc = (presc_q == PreW'(SCAN_DIV - 1));
    presc_d  = presc_tc ? '0 : presc_q + 1'b1;
    idx_d    = idx_q;
    if (presc_tc) begin
      idx_d = (idx_q == IdxW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end
  end

  // Output mux and leading-zero blanking, computed from next-state values so
  // the registered outputs move on the same edge as the index.
  always_comb begin
    upper_zero = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (i >= int'(idx_d) && disp_d[i*BCD_W +: BCD_W] != '0) begin
        upper_zero = 1'b0;
      end
    end
    bcd_out_d = disp_d[idx_d*BCD_W +: BCD_W];
    if (upper_zero && idx_d != '0) begin
      en_d = '1;
    end else begin
      en_d = ~(DIGITS'(1) << idx_d);
    end
  end

  // Display, scan and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_q    <= '0;
      presc_q   <= '0;
      idx_q     <= '0;
      bcd_out_q <= '0;
      en_q      <= ~DIGITS'(1);
    end else begin
      disp_q    <= disp_d;
      presc_q   <= presc_d;
      idx_q     <= idx_d;
      bcd_out_q <= bcd_out_d;
      en_q      <= en_d;
    end
  end

  assign {bus.bcd_a, bus.bcd_b, bus.bcd_c, bus.bcd_d} = bcd_out_q;
  assign bus.digit_en_n = en_q;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Self-checking bench for bcd_display_scanner with a behavioural model.
module tb_bcd_display_scanner;

  localparam int BIN_W    = 14;
  localparam int DIGITS   = 4;
  localparam int SCAN_DIV = 4;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  bcd_display_scanner_if #(.BIN_W(BIN_W), .DIGITS(DIGITS)) bus ();

  bcd_display_scanner #(
    .BIN_W    (BIN_W),
    .DIGITS   (DIGITS),
    .SCAN_DIV (SCAN_DIV)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural model: edges since reset, conversion countdown, display value.
  int   m_k;
  int   m_left;
  int   m_pend;
  int   m_disp;
  logic m_ovf;
  logic m_done;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_k    <= 0;
      m_left <= 0;
      m_pend <= 0;
      m_disp <= 0;
      m_ovf  <= 1'b0;
      m_done <= 1'b0;
    end else begin
      m_k    <= m_k + 1;
      m_done <= 1'b0;
      if (m_left == 0) begin
        if (bus.load) begin
          m_left <= BIN_W + 1;
          m_pend <= (int'(bus.bin_in) > 9999) ? 9999 : int'(bus.bin_in);
          m_ovf  <= int'(bus.bin_in) > 9999;
        end
      end else begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_disp <= m_pend;
          m_done <= 1'b1;
        end
      end
    end
  end

  // Expected {bcd, digit_en_n} after k edges while showing decimal value val.
  function automatic logic [7:0] exp_scan(input int k, input int val);
    int         idx;
    int         p;
    int         dig;
    logic [3:0] one;
    logic [3:0] en;
    one = 4'b0001;
    idx = (k / SCAN_DIV) % DIGITS;
    p   = 1;
    for (int i = 0; i < idx; i++) p = p * 10;
    dig = (val / p) % 10;
    if (idx != 0 && val < p) en = 4'b1111;
    else en = ~(one << idx);
    return {dig[3:0], en};
  endfunction

  int         exp_dig[4];
  logic [3:0] exp_en[4];

  function automatic logic [3:0] got_bcd();
    return {bus.bcd_a, bus.bcd_b, bus.bcd_c, bus.bcd_d};
  endfunction

  task automatic do_load(input int v);
    @(negedge clk);
    bus.load   = 1'b1;
    bus.bin_in = BIN_W'(v);
    @(negedge clk);
    bus.load   = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (bus.done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (bus.done !== 1'b1) begin
      bad++;
      $display("FAIL wait_done: done=%b after %0d cycles, required 1", bus.done, n);
    end
  endtask

  task automatic test_reset();
    logic [3:0] en_exp;
    rst        = 1'b1;
    bus.load   = 1'b0;
    bus.bin_in = '0;
    repeat (2) @(negedge clk);
    total++;
    if (bus.digit_en_n !== 4'b1110 || got_bcd() !== 4'b0000 || bus.busy !== 1'b0 ||
        bus.done !== 1'b0 || bus.overflow !== 1'b0) begin
      bad++;
      $display("FAIL reset_hold: en=%b bcd=%b busy=%b done=%b ovf=%b, required 1110 0000 0 0 0",
               bus.digit_en_n, got_bcd(), bus.busy, bus.done, bus.overflow);
    end
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      en_exp = (((m_k / SCAN_DIV) % DIGITS) == 0) ? 4'b1110 : 4'b1111;
      total++;
      if (bus.digit_en_n !== en_exp || got_bcd() !== 4'b0000) begin
        bad++;
        $display("FAIL reset_scan k=%0d: en=%b bcd=%b, required %b 0000",
                 m_k, bus.digit_en_n, got_bcd(), en_exp);
      end
    end
  endtask

  task automatic test_latency();
    int busy_n;
    int done_n;
    int w;
    busy_n = 0;
    done_n = 0;
    do_load(1234);
    for (int i = 0; i < 30; i++) begin
      if (bus.busy === 1'b1) busy_n++;
      if (bus.done === 1'b1) done_n++;
      @(negedge clk);
    end
    total++;
    if (busy_n != BIN_W + 1) begin
      bad++;
      $display("FAIL latency_busy: busy cycles=%0d, required %0d", busy_n, BIN_W + 1);
    end
    total++;
    if (done_n != 1) begin
      bad++;
      $display("FAIL latency_done: done pulses=%0d, required 1", done_n);
    end
    w = 0;
    while ((m_k % (SCAN_DIV * DIGITS)) != 0 && w < 20) begin
      @(negedge clk);
      w++;
    end
    for (int j = 0; j < SCAN_DIV * DIGITS; j++) begin
      total++;
      if (got_bcd() !== 4'(exp_dig[j / SCAN_DIV]) || bus.digit_en_n !== exp_en[j / SCAN_DIV]) begin
        bad++;
        $display("FAIL scan_order j=%0d: bcd=%0d en=%b, required %0d %b", j, got_bcd(),
                 bus.digit_en_n, exp_dig[j / SCAN_DIV], exp_en[j / SCAN_DIV]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_blanking();
    int vals[3];
    logic [7:0] e;
    vals[0] = 7;
    vals[1] = 0;
    vals[2] = 105;
    for (int v = 0; v < 3; v++) begin
      do_load(vals[v]);
      wait_done();
      for (int i = 0; i < SCAN_DIV * DIGITS; i++) begin
        e = exp_scan(m_k, vals[v]);
        total++;
        if (got_bcd() !== e[7:4] || bus.digit_en_n !== e[3:0]) begin
          bad++;
          $display("FAIL blank val=%0d k=%0d: bcd=%0d en=%b, required %0d %b", vals[v], m_k,
                   got_bcd(), bus.digit_en_n, e[7:4], e[3:0]);
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_saturation();
    logic [7:0] e;
    do_load(12000);
    wait_done();
    total++;
    if (bus.overflow !== 1'b1) begin
      bad++;
      $display("FAIL sat_overflow: overflow=%b, required 1", bus.overflow);
    end
    for (int i = 0; i < SCAN_DIV * DIGITS; i++) begin
      e = exp_scan(m_k, 9999);
      total++;
      if (got_bcd() !== e[7:4] || bus.digit_en_n !== e[3:0]) begin
        bad++;
        $display("FAIL sat_scan k=%0d: bcd=%0d en=%b, required %0d %b", m_k, got_bcd(),
                 bus.digit_en_n, e[7:4], e[3:0]);
      end
      @(negedge clk);
    end
    do_load(42);
    wait_done();
    total++;
    if (bus.overflow !== 1'b0) begin
      bad++;
      $display("FAIL sat_clear: overflow=%b, required 0", bus.overflow);
    end
    for (int i = 0; i < SCAN_DIV * DIGITS; i++) begin
      e = exp_scan(m_k, 42);
      total++;
      if (got_bcd() !== e[7:4] || bus.digit_en_n !== e[3:0]) begin
        bad++;
        $display("FAIL sat_42 k=%0d: bcd=%0d en=%b, required %0d %b", m_k, got_bcd(),
                 bus.digit_en_n, e[7:4], e[3:0]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_busy_collision();
    logic [7:0] e;
    do_load(1111);
    @(negedge clk);
    bus.load   = 1'b1;
    bus.bin_in = BIN_W'(5678);
    @(negedge clk);
    bus.load   = 1'b0;
    wait_done();
    for (int i = 0; i < 24; i++) begin
      e = exp_scan(m_k, 1111);
      total++;
      if (got_bcd() !== e[7:4] || bus.digit_en_n !== e[3:0] || bus.busy !== 1'b0) begin
        bad++;
        $display("FAIL collision k=%0d: bcd=%0d en=%b busy=%b, required %0d %b 0", m_k,
                 got_bcd(), bus.digit_en_n, bus.busy, e[7:4], e[3:0]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_load_held();
    int first;
    int second;
    int n;
    n      = 0;
    first  = -1;
    second = -1;
    @(negedge clk);
    bus.load   = 1'b1;
    bus.bin_in = BIN_W'(2468);
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      if (i == 19) bus.load = 1'b0;
      if (bus.done === 1'b1) begin
        if (n == 0) first = i;
        else if (n == 1) second = i;
        n++;
      end
    end
    total++;
    if (n != 2) begin
      bad++;
      $display("FAIL held_count: done pulses=%0d, required 2", n);
    end
    total++;
    if (second - first != 16) begin
      bad++;
      $display("FAIL held_spacing: spacing=%0d, required 16", second - first);
    end
  endtask

  task automatic test_random();
    int v;
    int sat;
    logic [7:0] e;
    for (int t = 0; t < 12; t++) begin
      v   = int'($urandom_range(0, 16383));
      sat = (v > 9999) ? 9999 : v;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      do_load(v);
      wait_done();
      total++;
      if (bus.overflow !== (v > 9999) || bus.done !== m_done) begin
        bad++;
        $display("FAIL rand_ovf v=%0d: overflow=%b done=%b, required %b %b", v, bus.overflow,
                 bus.done, v > 9999, m_done);
      end
      for (int i = 0; i < SCAN_DIV * DIGITS; i++) begin
        e = exp_scan(m_k, sat);
        total++;
        if (got_bcd() !== e[7:4] || bus.digit_en_n !== e[3:0] || got_bcd() > 4'd9 ||
            bus.busy !== (m_left != 0)) begin
          bad++;
          $display("FAIL rand_scan v=%0d k=%0d: bcd=%0d en=%b busy=%b, required %0d %b %b", v,
                   m_k, got_bcd(), bus.digit_en_n, bus.busy, e[7:4], e[3:0], m_left != 0);
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] e;
    do_load(4321);
    wait_done();
    do_load(9876);
    repeat (6) @(negedge clk);
    total++;
    if (bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL mid_busy_before: busy=%b, required 1", bus.busy);
    end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (bus.digit_en_n !== 4'b1110 || got_bcd() !== 4'b0000 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL mid_async: en=%b bcd=%b busy=%b, required 1110 0000 0", bus.digit_en_n,
               got_bcd(), bus.busy);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 24; i++) begin
      e = exp_scan(m_k, 0);
      total++;
      if (got_bcd() !== e[7:4] || bus.digit_en_n !== e[3:0] || bus.busy !== 1'b0 ||
          bus.done !== 1'b0) begin
        bad++;
        $display("FAIL mid_after k=%0d: bcd=%0d en=%b busy=%b done=%b, required %0d %b 0 0",
                 m_k, got_bcd(), bus.digit_en_n, bus.busy, bus.done, e[7:4], e[3:0]);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    exp_dig[0] = 4;
    exp_dig[1] = 3;
    exp_dig[2] = 2;
    exp_dig[3] = 1;
    exp_en[0]  = 4'b1110;
    exp_en[1]  = 4'b1101;
    exp_en[2]  = 4'b1011;
    exp_en[3]  = 4'b0111;
    test_reset();
    test_latency();
    test_blanking();
    test_saturation();
    test_busy_collision();
    test_load_held();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
